// File: rtl/fir_coef_loader.sv
// fir_coef_loader: assembles seven 16-bit FIR coefficients from an MCU byte
// stream into shadow registers and copies the whole set to the active outputs
// atomically on a filter sample boundary once a commit has been requested.
//
// Frame format: command byte {4'hA, index}. Index 0..6 is followed by a high
// data byte and a low data byte. Index 4'hF requests a commit. Anything else
// is a protocol error. A stalled frame is abandoned after TIMEOUT_CYCLES idle
// cycles between bytes.
module fir_coef_loader #(
  parameter int          NUM_TAPS       = 7,
  parameter logic [15:0] DEFAULT_COEF   = 16'd1000,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        sample_tick,
  output logic [15:0] coef_0,
  output logic [15:0] coef_1,
  output logic [15:0] coef_2,
  output logic [15:0] coef_3,
  output logic [15:0] coef_4,
  output logic [15:0] coef_5,
  output logic [15:0] coef_6,
  output logic        commit_pending,
  output logic        coef_updated,
  output logic        frame_err
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     CMD_TAG  = 4'hA;
  localparam logic [3:0]     IDX_CMT  = 4'hF;
  localparam logic [3:0]     IDX_LAST = 4'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GET_HI = 2'd1,
    S_GET_LO = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_index;
  logic [3:0]       w_index_next;
  logic [7:0]       r_hold;
  logic [7:0]       w_hold_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_err;
  logic             w_commit_cmd;
  logic             w_shadow_we;
  logic             w_do_copy;

  logic             r_commit_pending;
  logic             r_coef_updated;
  logic             r_frame_err;

  logic [15:0]      r_shadow [NUM_TAPS];
  logic [15:0]      r_active [NUM_TAPS];

  // A copy happens only when a commit is already pending at the tick edge;
  // the active registers therefore see shadow values from before this edge.
  assign w_do_copy = sample_tick & r_commit_pending;

  // Frame decoder: next state, byte latches, timeout counter and event strobes.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_hold_next  = r_hold;
    w_cnt_next   = r_cnt;
    w_err        = 1'b0;
    w_commit_cmd = 1'b0;
    w_shadow_we  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (wr_en) begin
          if (wr_data[7:4] != CMD_TAG) begin
            w_err = 1'b1;
          end else if (wr_data[3:0] <= IDX_LAST) begin
            w_index_next = wr_data[3:0];
            w_state_next = S_GET_HI;
          end else if (wr_data[3:0] == IDX_CMT) begin
            w_commit_cmd = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end

      S_GET_HI: begin
        if (wr_en) begin
          // A byte in the final counted cycle still wins over the timeout.
          w_hold_next  = wr_data;
          w_state_next = S_GET_LO;
          w_cnt_next   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_next = S_IDLE;
          w_err        = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_GET_LO: begin
        if (wr_en) begin
          w_shadow_we  = 1'b1;
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_next = S_IDLE;
          w_err        = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Control registers: FSM state, latches, commit handshake and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_index          <= '0;
      r_hold           <= '0;
      r_cnt            <= '0;
      r_commit_pending <= 1'b0;
      r_coef_updated   <= 1'b0;
      r_frame_err      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_index        <= w_index_next;
      r_hold         <= w_hold_next;
      r_cnt          <= w_cnt_next;
      r_frame_err    <= w_err;
      r_coef_updated <= w_do_copy;
      // A fresh commit request always leaves pending set, even if a copy of
      // the older request happens on this same edge.
      if (w_commit_cmd) begin
        r_commit_pending <= 1'b1;
      end else if (w_do_copy) begin
        r_commit_pending <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic w_tap_we;
      assign w_tap_we = w_shadow_we && (r_index == 4'(gi));

      // Shadow coefficient: written only when a complete frame finishes.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_shadow[gi] <= DEFAULT_COEF;
        end else if (w_tap_we) begin
          r_shadow[gi] <= {r_hold, wr_data};
        end
      end

      // Active coefficient: takes the shadow value on a committed sample tick.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_active[gi] <= DEFAULT_COEF;
        end else if (w_do_copy) begin
          r_active[gi] <= r_shadow[gi];
        end
      end
    end
  endgenerate

  assign coef_0         = r_active[0];
  assign coef_1         = r_active[1];
  assign coef_2         = r_active[2];
  assign coef_3         = r_active[3];
  assign coef_4         = r_active[4];
  assign coef_5         = r_active[5];
  assign coef_6         = r_active[6];
  assign commit_pending = r_commit_pending;
  assign coef_updated   = r_coef_updated;
  assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed testbench for fir_coef_loader. Inputs change on the falling edge;
// outputs are observed on the falling edge, half a cycle after the design's
// rising edge.
module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        sample_tick = 1'b0;
  logic [15:0] coef_0, coef_1, coef_2, coef_3, coef_4, coef_5, coef_6;
  logic        commit_pending, coef_updated, frame_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fir_coef_loader dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .sample_tick   (sample_tick),
    .coef_0        (coef_0),
    .coef_1        (coef_1),
    .coef_2        (coef_2),
    .coef_3        (coef_3),
    .coef_4        (coef_4),
    .coef_5        (coef_5),
    .coef_6        (coef_6),
    .commit_pending(commit_pending),
    .coef_updated  (coef_updated),
    .frame_err     (frame_err)
  );

  // One byte strobe lasting exactly one cycle; consecutive calls are back-to-back.
  task automatic send_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
    $display("tx byte %02h  pend=%0b err=%0b", b, commit_pending, frame_err);
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    $display("tick  coef=%0d,%0d,%0d,%0d,%0d,%0d,%0d upd=%0b", coef_0, coef_1,
             coef_2, coef_3, coef_4, coef_5, coef_6, coef_updated);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] c [7];
    rst = 1'b1;
    idle_cycles(5);
    rst = 1'b0;
    @(negedge clk);
    c = '{coef_0, coef_1, coef_2, coef_3, coef_4, coef_5, coef_6};
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (c[i] !== 16'd1000) $display("FAIL reset_coef%0d got %0d want 1000", i, c[i]);
      else n_pass++;
    end
    n_total++;
    if ({commit_pending, coef_updated, frame_err} !== 3'b000)
      $display("FAIL reset_flags got %03b want 000", {commit_pending, coef_updated, frame_err});
    else n_pass++;
  endtask

  task automatic test_load_commit();
    logic [15:0] c [7];
    send_byte(8'hA2);
    send_byte(8'h0E);
    send_byte(8'h56);
    send_byte(8'hAF);
    n_total++;
    if (commit_pending !== 1'b1) $display("FAIL lc_pending got %0b want 1", commit_pending);
    else n_pass++;
    idle_cycles(9);
    n_total++;
    if (coef_2 !== 16'd1000) $display("FAIL lc_before_tick coef_2 got %0d want 1000", coef_2);
    else n_pass++;
    n_total++;
    if (commit_pending !== 1'b1) $display("FAIL lc_pending_hold got %0b want 1", commit_pending);
    else n_pass++;
    pulse_tick();
    n_total++;
    if (coef_2 !== 16'd3670) $display("FAIL lc_coef_2 got %0d want 3670", coef_2);
    else n_pass++;
    n_total++;
    if (coef_updated !== 1'b1) $display("FAIL lc_updated got %0b want 1", coef_updated);
    else n_pass++;
    n_total++;
    if (commit_pending !== 1'b0) $display("FAIL lc_pending_clr got %0b want 0", commit_pending);
    else n_pass++;
    c = '{coef_0, coef_1, coef_2, coef_3, coef_4, coef_5, coef_6};
    for (int i = 0; i < 7; i++) begin
      if (i != 2) begin
        n_total++;
        if (c[i] !== 16'd1000) $display("FAIL lc_other_coef%0d got %0d want 1000", i, c[i]);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_total++;
    if (coef_updated !== 1'b0) $display("FAIL lc_updated_once got %0b want 0", coef_updated);
    else n_pass++;
  endtask

  task automatic test_bad_cmd();
    send_byte(8'hA7);
    n_total++;
    if (frame_err !== 1'b1) $display("FAIL bad_A7 frame_err got %0b want 1", frame_err);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (frame_err !== 1'b0) $display("FAIL bad_pulse_width frame_err got %0b want 0", frame_err);
    else n_pass++;
    send_byte(8'h5F);
    n_total++;
    if (frame_err !== 1'b1) $display("FAIL bad_5F frame_err got %0b want 1", frame_err);
    else n_pass++;
    send_byte(8'hA0);
    send_byte(8'h02);
    send_byte(8'h19);
    send_byte(8'hAF);
    pulse_tick();
    n_total++;
    if (coef_0 !== 16'd537) $display("FAIL bad_followup coef_0 got %0d want 537", coef_0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc;
    send_byte(8'hA3);
    send_byte(8'h11);
    cyc = 0;
    while (frame_err !== 1'b1 && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
    $display("timeout after %0d idle cycles", cyc);
    n_total++;
    if (cyc !== 1000) $display("FAIL timeout_cycles got %0d want 1000", cyc);
    else n_pass++;
    send_byte(8'hAF);
    pulse_tick();
    n_total++;
    if (coef_3 !== 16'd1000) $display("FAIL timeout_coef_3 got %0d want 1000", coef_3);
    else n_pass++;
    n_total++;
    if (coef_2 !== 16'd3670) $display("FAIL timeout_coef_2 got %0d want 3670", coef_2);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    send_byte(8'hAF);
    send_byte(8'hA5);
    send_byte(8'h07);
    sample_tick = 1'b1;
    send_byte(8'hC9);
    sample_tick = 1'b0;
    n_total++;
    if (coef_5 !== 16'd1000) $display("FAIL sim_part1 coef_5 got %0d want 1000", coef_5);
    else n_pass++;
    n_total++;
    if (coef_updated !== 1'b1) $display("FAIL sim_updated got %0b want 1", coef_updated);
    else n_pass++;
    n_total++;
    if (commit_pending !== 1'b0) $display("FAIL sim_pending got %0b want 0", commit_pending);
    else n_pass++;
    pulse_tick();
    n_total++;
    if (coef_5 !== 16'd1000) $display("FAIL sim_no_pending coef_5 got %0d want 1000", coef_5);
    else n_pass++;
    send_byte(8'hAF);
    pulse_tick();
    n_total++;
    if (coef_5 !== 16'd1993) $display("FAIL sim_part2 coef_5 got %0d want 1993", coef_5);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA1);
    send_byte(8'h12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (coef_5 !== 16'd1000) $display("FAIL rm_reset_coef_5 got %0d want 1000", coef_5);
    else n_pass++;
    send_byte(8'h34);
    n_total++;
    if (frame_err !== 1'b1) $display("FAIL rm_bad_cmd frame_err got %0b want 1", frame_err);
    else n_pass++;
    send_byte(8'hAF);
    pulse_tick();
    n_total++;
    if (coef_1 !== 16'd1000) $display("FAIL rm_coef_1 got %0d want 1000", coef_1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_byte(8'hA6);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'hA4);
    send_byte(8'h00);
    send_byte(8'h2A);
    send_byte(8'hAF);
    pulse_tick();
    n_total++;
    if (coef_6 !== 16'hBEEF) $display("FAIL b2b_coef_6 got %04h want beef", coef_6);
    else n_pass++;
    n_total++;
    if (coef_4 !== 16'd42) $display("FAIL b2b_coef_4 got %0d want 42", coef_4);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_commit();
    test_bad_cmd();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
